// File: rtl/sram_serial_burst_ctrl_if.sv
// Bus bundle for the serial-to-SRAM bridge: host serial port, SRAM read data in,
// and the SRAM address/data/strobes plus frame status out.
interface sram_serial_burst_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 9
);
  logic          BGN;
  logic [1:0]    CTRL;
  logic          SI;
  logic          LOAD_N;
  logic [DW-1:0] PI;
  logic          RDY;
  logic          D_WE;
  logic          CEN;
  logic          SO;
  logic [AW-1:0] A;
  logic [DW-1:0] PO;

  modport master (
    output BGN, CTRL, SI, LOAD_N, PI,
    input  RDY, D_WE, CEN, SO, A, PO
  );

  modport slave (
    input  BGN, CTRL, SI, LOAD_N, PI,
    output RDY, D_WE, CEN, SO, A, PO
  );
endinterface

// File: rtl/sram_serial_burst_ctrl.sv
// Bit-serial host bridge to a 1-cycle-latency single-port SRAM: single and burst
// writes/reads with address auto-increment, LSB-first shifting and LOAD_N stalls.
module sram_serial_burst_ctrl #(
  parameter int DW = 8,
  parameter int AW = 9,
  parameter int CW = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  sram_serial_burst_ctrl_if.slave bus
);

  localparam int BCW = $clog2(AW + CW + DW + 1);
  localparam logic [BCW-1:0] ADDR_BITS  = BCW'(AW);
  localparam logic [BCW-1:0] HDR_S_LAST = BCW'(AW - 1);
  localparam logic [BCW-1:0] HDR_B_LAST = BCW'(AW + CW - 1);
  localparam logic [BCW-1:0] WORD_LAST  = BCW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, WR, RD_REQ, RD_CAP, RD_SHIFT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wsr_q, wsr_d;
  logic [DW-1:0] rsr_q, rsr_d;
  logic          rdy_q, rdy_d;
  logic          we_q, we_d;
  logic          cen_q, cen_d;
  logic          so_q, so_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] po_q, po_d;
  logic          hdr_last;

  assign bus.RDY  = rdy_q;
  assign bus.D_WE = we_q;
  assign bus.CEN  = cen_q;
  assign bus.SO   = so_q;
  assign bus.A    = a_q;
  assign bus.PO   = po_q;

  assign hdr_last = mode_q[1] ? (bit_cnt_q == HDR_B_LAST) : (bit_cnt_q == HDR_S_LAST);

  // Outputs are computed alongside the next state so each strobe is registered
  // and lines up with the state it belongs to.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wsr_d     = wsr_q;
    rsr_d     = rsr_q;
    rdy_d     = rdy_q;
    we_d      = 1'b0;
    cen_d     = 1'b0;
    so_d      = so_q;
    a_d       = a_q;
    po_d      = po_q;

    case (state_q)
      IDLE: begin
        rdy_d = 1'b0;
        if (bus.BGN) begin
          mode_d    = bus.CTRL;
          bit_cnt_d = '0;
          cnt_d     = '0;
          addr_d    = '0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (!bus.LOAD_N) begin
          if (bit_cnt_q < ADDR_BITS) addr_d = {bus.SI, addr_q[AW-1:1]};
          else                       cnt_d  = {bus.SI, cnt_q[CW-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (hdr_last) begin
            bit_cnt_d = '0;
            if (mode_q[0]) begin
              state_d = RD_REQ;
              cen_d   = 1'b1;
              a_d     = addr_d;
            end else begin
              state_d = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (!bus.LOAD_N) begin
          wsr_d     = {bus.SI, wsr_q[DW-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == WORD_LAST) begin
            bit_cnt_d = '0;
            state_d   = WR;
            cen_d     = 1'b1;
            we_d      = 1'b1;
            a_d       = addr_q;
            po_d      = wsr_d;
          end
        end
      end
      WR: begin
        addr_d = addr_q + AW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = WDATA;
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        rsr_d     = bus.PI;
        so_d      = bus.PI[0];
        bit_cnt_d = '0;
        state_d   = RD_SHIFT;
      end
      RD_SHIFT: begin
        if (!bus.LOAD_N) begin
          if (bit_cnt_q == WORD_LAST) begin
            bit_cnt_d = '0;
            addr_d    = addr_q + AW'(1);
            if (cnt_q == '0) begin
              state_d = DONE;
              rdy_d   = 1'b1;
            end else begin
              cnt_d   = cnt_q - CW'(1);
              state_d = RD_REQ;
              cen_d   = 1'b1;
              a_d     = addr_d;
            end
          end else begin
            rsr_d     = rsr_q >> 1;
            so_d      = rsr_q[1];
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      DONE: rdy_d = 1'b1;
      default: state_d = IDLE;
    endcase

    // Abort wins over any transition, including the one into WR, so a
    // half-shifted or just-completed word never reaches the SRAM.
    if (state_q != IDLE && !bus.BGN) begin
      state_d = IDLE;
      rdy_d   = 1'b0;
      cen_d   = 1'b0;
      we_d    = 1'b0;
      a_d     = a_q;
      po_d    = po_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wsr_q     <= '0;
      rsr_q     <= '0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      cen_q     <= 1'b0;
      so_q      <= 1'b0;
      a_q       <= '0;
      po_q      <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wsr_q     <= wsr_d;
      rsr_q     <= rsr_d;
      rdy_q     <= rdy_d;
      we_q      <= we_d;
      cen_q     <= cen_d;
      so_q      <= so_d;
      a_q       <= a_d;
      po_q      <= po_d;
    end
  end

endmodule

// File: tb/tb_sram_serial_burst_ctrl.sv
// Bench for the serial SRAM bridge: directed frame table, abort/reset sequences,
// and random frames checked against a flat memory reference model.
module tb_sram_serial_burst_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef logic [DW-1:0] word_arr_t [16];
  typedef logic [AW-1:0] addr_arr_t [16];

  typedef struct {
    logic [1:0]    ctrl;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    bit            stall;
    logic [DW-1:0] d  [4];
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sram_serial_burst_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  sram_serial_burst_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // SRAM behavioural model (1-cycle read latency)
  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] q;
  assign bus.PI = q;
  always @(posedge CLK) begin
    if (bus.CEN) begin
      if (bus.D_WE) sram[bus.A] <= bus.PO;
      else          q <= sram[bus.A];
    end
  end

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [AW+DW-1:0] wlog [$];
  always @(negedge CLK) if (bus.CEN && bus.D_WE) wlog.push_back({bus.A, bus.PO});

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit stall);
    if (stall) begin
      bus.LOAD_N = 1'b1;
      bus.SI     = ~b;
      @(negedge CLK);
    end
    bus.SI     = b;
    bus.LOAD_N = 1'b0;
    @(negedge CLK);
  endtask

  task automatic recv_word(input bit stall, output logic [DW-1:0] w);
    bus.LOAD_N = 1'b1;
    repeat (2) @(negedge CLK);
    for (int b = 0; b < DW; b++) begin
      if (stall) begin
        bus.LOAD_N = 1'b1;
        @(negedge CLK);
      end
      w[b]       = bus.SO;
      bus.LOAD_N = 1'b0;
      @(negedge CLK);
    end
    bus.LOAD_N = 1'b1;
  endtask

  task automatic send_header(input logic [1:0] ctrl, input logic [AW-1:0] addr,
                             input logic [CW-1:0] cnt, input bit stall);
    for (int i = 0; i < AW; i++) send_bit(addr[i], stall);
    if (ctrl[1]) for (int i = 0; i < CW; i++) send_bit(cnt[i], stall);
  endtask

  task automatic do_frame(input string nm, input logic [1:0] ctrl, input logic [AW-1:0] addr,
                          input logic [CW-1:0] cnt, input bit stall,
                          input word_arr_t d, input addr_arr_t ea, input word_arr_t ed);
    int unsigned n;
    int unsigned t0;
    logic [DW-1:0] w;
    n = ctrl[1] ? int'(cnt) + 1 : 1;
    wlog.delete();
    bus.BGN    = 1'b1;
    bus.CTRL   = ctrl;
    bus.LOAD_N = 1'b1;
    @(negedge CLK);
    t0       = cyc;
    bus.CTRL = ~ctrl;
    send_header(ctrl, addr, cnt, stall);
    if (!ctrl[0]) begin
      for (int unsigned k = 0; k < n; k++) begin
        for (int b = 0; b < DW; b++) send_bit(d[k][b], stall);
        bus.LOAD_N = 1'b1;
        @(negedge CLK);
      end
    end else begin
      for (int unsigned k = 0; k < n; k++) begin
        recv_word(stall, w);
        chk($sformatf("%s rd%0d", nm, k), 32'(w), 32'(ed[k]));
      end
    end
    chk($sformatf("%s rdy", nm), 32'(bus.RDY), 32'd1);
    chk($sformatf("%s a_hold", nm), 32'(bus.A), 32'(ea[n-1]));
    if (ctrl == 2'b00)
      chk($sformatf("%s latency", nm), cyc - t0, stall ? 2*(AW+DW)+1 : AW+DW+1);
    if (!ctrl[0]) begin
      chk($sformatf("%s wr_count", nm), 32'(wlog.size()), n);
      for (int unsigned k = 0; k < n && k < wlog.size(); k++)
        chk($sformatf("%s wr%0d", nm, k), 32'(wlog[k]), 32'({ea[k], ed[k]}));
    end
    bus.BGN    = 1'b0;
    bus.LOAD_N = 1'b1;
    @(negedge CLK);
    chk($sformatf("%s rdy_low", nm), 32'(bus.RDY), 32'd0);
  endtask

  vec_t tbl [7];

  initial begin
    word_arr_t d, ed;
    addr_arr_t ea;
    logic [1:0]    ctrl;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    logic [DW-1:0] w;
    logic [DW-1:0] v;
    bit            stall;
    int            n;

    tbl[0] = '{ctrl:2'b00, addr:9'h020, cnt:4'd0, stall:1'b0,
               d:'{8'h3C, 8'h00, 8'h00, 8'h00}, ea:'{9'h020, 9'h000, 9'h000, 9'h000},
               ed:'{8'h3C, 8'h00, 8'h00, 8'h00}};
    tbl[1] = '{ctrl:2'b01, addr:9'h020, cnt:4'd0, stall:1'b0,
               d:'{8'h00, 8'h00, 8'h00, 8'h00}, ea:'{9'h020, 9'h000, 9'h000, 9'h000},
               ed:'{8'h3C, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{ctrl:2'b10, addr:9'h1FE, cnt:4'd3, stall:1'b0,
               d:'{8'hAB, 8'hCD, 8'hEF, 8'h12}, ea:'{9'h1FE, 9'h1FF, 9'h000, 9'h001},
               ed:'{8'hAB, 8'hCD, 8'hEF, 8'h12}};
    tbl[3] = '{ctrl:2'b11, addr:9'h1FE, cnt:4'd3, stall:1'b0,
               d:'{8'h00, 8'h00, 8'h00, 8'h00}, ea:'{9'h1FE, 9'h1FF, 9'h000, 9'h001},
               ed:'{8'hAB, 8'hCD, 8'hEF, 8'h12}};
    tbl[4] = '{ctrl:2'b00, addr:9'h033, cnt:4'd0, stall:1'b1,
               d:'{8'h5A, 8'h00, 8'h00, 8'h00}, ea:'{9'h033, 9'h000, 9'h000, 9'h000},
               ed:'{8'h5A, 8'h00, 8'h00, 8'h00}};
    tbl[5] = '{ctrl:2'b01, addr:9'h033, cnt:4'd0, stall:1'b1,
               d:'{8'h00, 8'h00, 8'h00, 8'h00}, ea:'{9'h033, 9'h000, 9'h000, 9'h000},
               ed:'{8'h5A, 8'h00, 8'h00, 8'h00}};
    tbl[6] = '{ctrl:2'b11, addr:9'h1FF, cnt:4'd1, stall:1'b1,
               d:'{8'h00, 8'h00, 8'h00, 8'h00}, ea:'{9'h1FF, 9'h000, 9'h000, 9'h000},
               ed:'{8'hCD, 8'hEF, 8'h00, 8'h00}};

    for (int i = 0; i < DEPTH; i++) begin
      v          = DW'($urandom);
      sram[i]   <= v;
      ref_mem[i] = v;
    end

    bus.BGN    = 1'b0;
    bus.CTRL   = 2'b00;
    bus.SI     = 1'b0;
    bus.LOAD_N = 1'b1;
    RST        = 1'b1;
    #1;
    chk("reset outputs", 32'({bus.RDY, bus.D_WE, bus.CEN, bus.SO, bus.A, bus.PO}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Directed frame table
    foreach (tbl[i]) begin
      for (int k = 0; k < 16; k++) begin
        d[k]  = (k < 4) ? tbl[i].d[k]  : '0;
        ea[k] = (k < 4) ? tbl[i].ea[k] : '0;
        ed[k] = (k < 4) ? tbl[i].ed[k] : '0;
      end
      do_frame($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].addr, tbl[i].cnt, tbl[i].stall, d, ea, ed);
      if (!tbl[i].ctrl[0]) begin
        n = tbl[i].ctrl[1] ? int'(tbl[i].cnt) + 1 : 1;
        for (int k = 0; k < n; k++) ref_mem[(int'(tbl[i].addr) + k) % DEPTH] = tbl[i].d[k];
      end
    end
    chk("po_hold", 32'(bus.PO), 32'h5A);

    // Abort a single write to 0x040 after 4 data bits
    for (int k = 0; k < 16; k++) begin d[k] = '0; ea[k] = 9'h040; ed[k] = '0; end
    do_frame("pre_abort", 2'b00, 9'h040, 4'd0, 1'b0, d, ea, ed);
    ref_mem[9'h040] = 8'h00;
    wlog.delete();
    bus.BGN = 1'b1; bus.CTRL = 2'b00; bus.LOAD_N = 1'b1;
    @(negedge CLK);
    send_header(2'b00, 9'h040, 4'd0, 1'b0);
    for (int b = 0; b < 4; b++) send_bit(1'b1, 1'b0);
    bus.BGN = 1'b0; bus.LOAD_N = 1'b1;
    @(negedge CLK);
    chk("abort rdy", 32'(bus.RDY), 32'd0);
    repeat (DW + 3) @(negedge CLK);
    chk("abort no_write", 32'(wlog.size()), 32'd0);
    ed[0] = ref_mem[9'h040];
    do_frame("abort readback", 2'b01, 9'h040, 4'd0, 1'b0, d, ea, ed);

    // Reset in the middle of a burst read
    bus.BGN = 1'b1; bus.CTRL = 2'b11; bus.LOAD_N = 1'b1;
    @(negedge CLK);
    send_header(2'b11, 9'h1FE, 4'd3, 1'b0);
    recv_word(1'b0, w);
    chk("rst_mid first word", 32'(w), 32'(ref_mem[9'h1FE]));
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid outputs", 32'({bus.RDY, bus.D_WE, bus.CEN, bus.SO, bus.A, bus.PO}), 32'd0);
    bus.BGN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 16; k++) begin ea[k] = 9'h1FF; ed[k] = '0; end
    ed[0] = ref_mem[9'h1FF];
    do_frame("post_reset rd", 2'b01, 9'h1FF, 4'd0, 1'b0, d, ea, ed);

    // Random frames against the memory model
    for (int r = 0; r < 40; r++) begin
      ctrl  = 2'($urandom_range(0, 3));
      addr  = AW'($urandom_range(0, DEPTH - 1));
      cnt   = ctrl[1] ? CW'($urandom_range(0, 5)) : '0;
      stall = ($urandom_range(0, 3) == 0);
      n     = int'(cnt) + 1;
      for (int k = 0; k < 16; k++) begin
        ea[k] = AW'((int'(addr) + k) % DEPTH);
        d[k]  = DW'($urandom);
        ed[k] = ctrl[0] ? ref_mem[(int'(addr) + k) % DEPTH] : d[k];
      end
      do_frame($sformatf("rnd%0d", r), ctrl, addr, cnt, stall, d, ea, ed);
      if (!ctrl[0])
        for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) % DEPTH] = d[k];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
